// File: rtl/sdram_clk_pkg.sv
// Shared types and helpers for the SDRAM clocking logic.
package sdram_clk_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } sup_state_t;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-stage synchroniser with synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_pll_supervisor.sv
// PLL lock supervisor: resets the PLL, qualifies lock, releases domain resets
// in staggered order, recovers from lock loss and latches a fault after
// repeated failed attempts.
module sdram_pll_supervisor
  import sdram_clk_pkg::*;
#(
  parameter int unsigned N_DOM            = 2,
  parameter int unsigned PLL_RST_CYC      = 8,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned STAGGER_CYC      = 16,
  parameter int unsigned MAX_RETRY        = 4,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             force_relock,
  output logic             pll_rst,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       state_o
);

  localparam int unsigned RST_W = cnt_w(PLL_RST_CYC);
  localparam int unsigned STB_W = cnt_w(LOCK_STABLE_CYC);
  localparam int unsigned TO_W  = cnt_w(LOCK_TIMEOUT_CYC);
  localparam int unsigned STG_W = cnt_w(STAGGER_CYC);
  localparam int unsigned RTY_W = cnt_w(MAX_RETRY);
  localparam int unsigned REL_W = cnt_w(N_DOM - 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYC - 1);
  localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE_CYC);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(N_DOM - 1);

  sup_state_t       state, state_nx;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nx;
  logic [STB_W-1:0] stb_cnt, stb_nx;
  logic [TO_W-1:0]  to_cnt, to_nx;
  logic [STG_W-1:0] stg_cnt, stg_nx;
  logic [RTY_W-1:0] rty_cnt, rty_nx;
  logic [REL_W-1:0] rel_idx, rel_nx;
  logic [CNT_W-1:0] llc_nx;
  logic [N_DOM-1:0] dom_nx;
  logic             lk_s;
  logic             lost;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  assign state_o = state;

  // Next-state, counter and output decode; outputs are computed from the
  // next state so the registered outputs line up with the state register.
  always_comb begin
    state_nx   = state;
    rst_cnt_nx = rst_cnt;
    stb_nx     = stb_cnt;
    to_nx      = to_cnt;
    stg_nx     = stg_cnt;
    rty_nx     = rty_cnt;
    rel_nx     = rel_idx;
    llc_nx     = lock_loss_cnt;
    lost       = 1'b0;
    dom_nx     = '0;

    case (state)
      PLL_RESET: begin
        if (rst_cnt == RST_LAST) begin
          state_nx   = WAIT_LOCK;
          rst_cnt_nx = '0;
          stb_nx     = '0;
          to_nx      = '0;
        end else begin
          rst_cnt_nx = rst_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (stb_cnt == STB_DONE) begin
          state_nx = RELEASE;
          rty_nx   = '0;
          to_nx    = '0;
          rel_nx   = '0;
          stg_nx   = '0;
        end else if (to_cnt == TO_LAST) begin
          rty_nx     = rty_cnt + 1'b1;
          state_nx   = (rty_nx == RTY_MAX) ? FAULT : PLL_RESET;
          rst_cnt_nx = '0;
        end else begin
          to_nx  = to_cnt + 1'b1;
          stb_nx = lk_s ? stb_cnt + 1'b1 : '0;
        end
      end
      RELEASE: begin
        if (!lk_s) begin
          lost = 1'b1;
        end else if (rel_idx == REL_LAST) begin
          state_nx = RUN;
        end else if (stg_cnt == STG_LAST) begin
          rel_nx = rel_idx + 1'b1;
          stg_nx = '0;
        end else begin
          stg_nx = stg_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lk_s) lost = 1'b1;
      end
      FAULT: begin
        state_nx = FAULT;
      end
      default: begin
        state_nx   = PLL_RESET;
        rst_cnt_nx = '0;
      end
    endcase

    if (lost) begin
      state_nx   = PLL_RESET;
      rst_cnt_nx = '0;
      if (lock_loss_cnt != '1) llc_nx = lock_loss_cnt + 1'b1;
    end

    // force_relock overrides any other transition but keeps the loss count.
    if (force_relock) begin
      state_nx   = PLL_RESET;
      rst_cnt_nx = '0;
      if (state != PLL_RESET) rty_nx = '0;
    end

    // Domains 0..rel_nx are out of reset; none outside RELEASE/RUN.
    if (state_nx == RELEASE || state_nx == RUN) begin
      for (int unsigned k = 0; k < N_DOM; k++) begin
        dom_nx[k] = (k <= 32'(rel_nx));
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state         <= PLL_RESET;
      rst_cnt       <= '0;
      stb_cnt       <= '0;
      to_cnt        <= '0;
      stg_cnt       <= '0;
      rty_cnt       <= '0;
      rel_idx       <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      dom_rst_n     <= '0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nx;
      rst_cnt       <= rst_cnt_nx;
      stb_cnt       <= stb_nx;
      to_cnt        <= to_nx;
      stg_cnt       <= stg_nx;
      rty_cnt       <= rty_nx;
      rel_idx       <= rel_nx;
      lock_loss_cnt <= llc_nx;
      pll_rst       <= (state_nx == PLL_RESET) || (state_nx == FAULT);
      dom_rst_n     <= dom_nx;
      ready         <= (state_nx == RUN);
      fault         <= (state_nx == FAULT);
    end
  end

endmodule
